// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive buffer: frame/data widths,
// the stored entry layout and the odd-parity check helper.
package uart_pkg;

    localparam int UART_DATA_W  = 8;
    localparam int UART_FRAME_W = 9;

    // One stored entry: parity-error flag above the received data byte.
    typedef struct packed {
        logic                   parity_err;
        logic [UART_DATA_W-1:0] data;
    } rx_entry_t;

    // Odd parity: the nine frame bits must XOR to 1, anything else is an error.
    function automatic logic frame_parity_err(input logic [UART_FRAME_W-1:0] frame);
        return ~^frame;
    endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// First-word-fall-through FIFO of rx_entry_t.
// Pointers carry one extra wrap bit so full and empty are told apart by
// comparing the MSB and the index bits; occupancy is the pointer difference.
// A push is accepted when full only if a pop happens in the same cycle.
// The head entry is read combinationally and masked to zero while empty.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                     Clk,
    input  logic                     Rst,
    input  logic                     wr_en,
    input  rx_entry_t                wr_entry,
    input  logic                     rd_en,
    output rx_entry_t                rd_entry,
    output logic                     rd_valid,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     push,
    output logic                     pop
);

    localparam int AW = $clog2(DEPTH);

    rx_entry_t       mem [DEPTH];
    logic [AW:0]     wr_ptr_reg;
    logic [AW:0]     rd_ptr_reg;
    logic [AW:0]     wr_ptr_next;
    logic [AW:0]     rd_ptr_next;
    logic [AW-1:0]   wr_idx;
    logic [AW-1:0]   rd_idx;
    logic            empty;

    assign wr_idx = wr_ptr_reg[AW-1:0];
    assign rd_idx = rd_ptr_reg[AW-1:0];

    // Flag decode from the wrap bit and the index bits.
    assign empty = (wr_ptr_reg == rd_ptr_reg);
    assign full  = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) && (wr_idx == rd_idx);
    assign count = wr_ptr_reg - rd_ptr_reg;

    assign rd_valid = !empty;
    assign pop      = rd_en && !empty;
    assign push     = wr_en && (!full || pop);

    // Head entry with no added latency; zero when nothing is stored.
    assign rd_entry = empty ? '0 : mem[rd_idx];

    // Pointer advance for accepted pushes and pops.
    always_comb begin
        wr_ptr_next = wr_ptr_reg;
        rd_ptr_next = rd_ptr_reg;
        if (push) begin
            wr_ptr_next = wr_ptr_reg + 1'b1;
        end
        if (pop) begin
            rd_ptr_next = rd_ptr_reg + 1'b1;
        end
    end

    // Pointer registers; reset discards every stored entry.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            wr_ptr_reg <= wr_ptr_next;
            rd_ptr_reg <= rd_ptr_next;
        end
    end

    // Storage write; contents are never reset, the empty mask hides stale data.
    always_ff @(posedge Clk) begin
        if (push) begin
            mem[wr_idx] <= wr_entry;
        end
    end

endmodule

// File: rtl/uart_rx_buffer.sv
// Receive buffer behind a UART receiver: checks odd parity on each frame,
// queues {parity_err, data} in a FWFT FIFO, and keeps a sticky overflow
// flag plus saturating dropped-frame and parity-error counters.
// ClrCnt wins over any same-cycle increment or overflow set.
module uart_rx_buffer
    import uart_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int CNT_W = 8
) (
    input  logic                        Clk,
    input  logic                        Rst,
    input  logic [UART_FRAME_W-1:0]     RxFrame,
    input  logic                        RxFrameValid,
    output logic [UART_DATA_W-1:0]      RdData,
    output logic                        RdParityErr,
    output logic                        RdValid,
    input  logic                        RdReady,
    output logic [$clog2(DEPTH):0]      Count,
    output logic                        Full,
    output logic                        Overflow,
    output logic [CNT_W-1:0]            OverflowCnt,
    output logic [CNT_W-1:0]            ParityErrCnt,
    input  logic                        ClrCnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    rx_entry_t          wr_entry;
    rx_entry_t          rd_entry;
    logic               push;
    logic               pop;
    logic               drop;
    logic               overflow_reg;
    logic               overflow_next;
    logic [CNT_W-1:0]   overflow_cnt_reg;
    logic [CNT_W-1:0]   overflow_cnt_next;
    logic [CNT_W-1:0]   parity_cnt_reg;
    logic [CNT_W-1:0]   parity_cnt_next;

    assign wr_entry.parity_err = frame_parity_err(RxFrame);
    assign wr_entry.data       = RxFrame[UART_DATA_W-1:0];

    uart_rx_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .Clk      (Clk),
        .Rst      (Rst),
        .wr_en    (RxFrameValid),
        .wr_entry (wr_entry),
        .rd_en    (RdReady),
        .rd_entry (rd_entry),
        .rd_valid (RdValid),
        .full     (Full),
        .count    (Count),
        .push     (push),
        .pop      (pop)
    );

    // A frame is dropped only when it was offered but the FIFO refused it.
    assign drop = RxFrameValid && !push;

    assign RdData      = rd_entry.data;
    assign RdParityErr = rd_entry.parity_err;

    assign Overflow     = overflow_reg;
    assign OverflowCnt  = overflow_cnt_reg;
    assign ParityErrCnt = parity_cnt_reg;

    // Next state of the sticky flag and the saturating counters.
    always_comb begin
        overflow_next     = overflow_reg;
        overflow_cnt_next = overflow_cnt_reg;
        parity_cnt_next   = parity_cnt_reg;
        if (ClrCnt) begin
            overflow_next     = 1'b0;
            overflow_cnt_next = '0;
            parity_cnt_next   = '0;
        end else begin
            if (drop) begin
                overflow_next = 1'b1;
                if (overflow_cnt_reg != CNT_MAX) begin
                    overflow_cnt_next = overflow_cnt_reg + 1'b1;
                end
            end
            if (push && wr_entry.parity_err && (parity_cnt_reg != CNT_MAX)) begin
                parity_cnt_next = parity_cnt_reg + 1'b1;
            end
        end
    end

    // Error status registers.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            overflow_reg     <= 1'b0;
            overflow_cnt_reg <= '0;
            parity_cnt_reg   <= '0;
        end else begin
            overflow_reg     <= overflow_next;
            overflow_cnt_reg <= overflow_cnt_next;
            parity_cnt_reg   <= parity_cnt_next;
        end
    end

endmodule

// File: tb/tb_uart_rx_buffer.sv
// Directed bench for uart_rx_buffer (DEPTH=8, CNT_W=2).
module tb_uart_rx_buffer;

    logic        Clk = 1'b0;
    logic        Rst = 1'b1;
    logic [8:0]  RxFrame = '0;
    logic        RxFrameValid = 1'b0;
    logic [7:0]  RdData;
    logic        RdParityErr;
    logic        RdValid;
    logic        RdReady = 1'b0;
    logic [3:0]  Count;
    logic        Full;
    logic        Overflow;
    logic [1:0]  OverflowCnt;
    logic [1:0]  ParityErrCnt;
    logic        ClrCnt = 1'b0;

    int checks = 0;
    int fails  = 0;

    uart_rx_buffer #(
        .DEPTH (8),
        .CNT_W (2)
    ) dut (
        .Clk          (Clk),
        .Rst          (Rst),
        .RxFrame      (RxFrame),
        .RxFrameValid (RxFrameValid),
        .RdData       (RdData),
        .RdParityErr  (RdParityErr),
        .RdValid      (RdValid),
        .RdReady      (RdReady),
        .Count        (Count),
        .Full         (Full),
        .Overflow     (Overflow),
        .OverflowCnt  (OverflowCnt),
        .ParityErrCnt (ParityErrCnt),
        .ClrCnt       (ClrCnt)
    );

    always #5 Clk = ~Clk;

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Frame with correct odd parity / with the parity bit inverted.
    function automatic logic [8:0] good(input logic [7:0] d);
        return {~^d, d};
    endfunction

    function automatic logic [8:0] bad(input logic [7:0] d);
        return {^d, d};
    endfunction

    initial begin
        // Reset state
        tick();
        chk("rst_count", 32'(Count), 32'd0);
        chk("rst_valid", 32'(RdValid), 32'd0);
        chk("rst_full", 32'(Full), 32'd0);
        chk("rst_ovf", 32'(Overflow), 32'd0);
        chk("rst_ovfcnt", 32'(OverflowCnt), 32'd0);
        chk("rst_parcnt", 32'(ParityErrCnt), 32'd0);
        chk("rst_data", 32'(RdData), 32'd0);
        chk("rst_perr", 32'(RdParityErr), 32'd0);
        Rst = 1'b0;
        tick();
        $display("reset released");

        // Single good frame 9'h155 into empty FIFO
        RxFrame = 9'h155; RxFrameValid = 1'b1;
        tick();
        RxFrameValid = 1'b0;
        chk("single_valid", 32'(RdValid), 32'd1);
        chk("single_data", 32'(RdData), 32'h55);
        chk("single_perr", 32'(RdParityErr), 32'd0);
        chk("single_count", 32'(Count), 32'd1);
        tick();
        chk("single_hold", 32'(RdData), 32'h55);
        $display("single frame 155 -> data=%0h count=%0d", RdData, Count);

        // Bad parity frame 9'h055 behind it
        RxFrame = 9'h055; RxFrameValid = 1'b1;
        tick();
        RxFrameValid = 1'b0;
        chk("bad_count", 32'(Count), 32'd2);
        chk("bad_parcnt", 32'(ParityErrCnt), 32'd1);
        RdReady = 1'b1;
        tick();
        RdReady = 1'b0;
        chk("bad_head_data", 32'(RdData), 32'h55);
        chk("bad_head_perr", 32'(RdParityErr), 32'd1);
        RdReady = 1'b1;
        tick();
        RdReady = 1'b0;
        chk("bad_pop_count", 32'(Count), 32'd0);
        chk("bad_pop_valid", 32'(RdValid), 32'd0);
        chk("empty_mask", 32'(RdData), 32'd0);
        $display("bad parity frame 055 -> parcnt=%0d", ParityErrCnt);

        // RdReady while empty has no effect
        RdReady = 1'b1;
        tick();
        RdReady = 1'b0;
        chk("empty_rd_count", 32'(Count), 32'd0);

        // Fill with 00..07 on consecutive cycles, then overflow with AA (bad parity)
        for (int i = 0; i < 8; i++) begin
            RxFrame = good(8'(i)); RxFrameValid = 1'b1;
            tick();
        end
        RxFrameValid = 1'b0;
        chk("fill_count", 32'(Count), 32'd8);
        chk("fill_full", 32'(Full), 32'd1);
        chk("fill_ovf", 32'(Overflow), 32'd0);
        RxFrame = bad(8'hAA); RxFrameValid = 1'b1;
        tick();
        RxFrameValid = 1'b0;
        chk("ovf_flag", 32'(Overflow), 32'd1);
        chk("ovf_cnt", 32'(OverflowCnt), 32'd1);
        chk("ovf_count", 32'(Count), 32'd8);
        chk("ovf_parcnt", 32'(ParityErrCnt), 32'd1);
        $display("overflow frame AA -> ovf=%0d ovfcnt=%0d", Overflow, OverflowCnt);
        for (int i = 0; i < 8; i++) begin
            chk("drain_data", 32'(RdData), 32'(i));
            chk("drain_perr", 32'(RdParityErr), 32'd0);
            RdReady = 1'b1;
            tick();
            RdReady = 1'b0;
        end
        chk("drain_count", 32'(Count), 32'd0);
        chk("drain_valid", 32'(RdValid), 32'd0);
        $display("drained 00..07");

        // Full with simultaneous push and pop
        for (int i = 0; i < 8; i++) begin
            RxFrame = good(8'h10 + 8'(i)); RxFrameValid = 1'b1;
            tick();
        end
        RxFrame = good(8'hBB); RxFrameValid = 1'b1; RdReady = 1'b1;
        tick();
        RxFrameValid = 1'b0; RdReady = 1'b0;
        chk("pp_count", 32'(Count), 32'd8);
        chk("pp_full", 32'(Full), 32'd1);
        chk("pp_ovfcnt", 32'(OverflowCnt), 32'd1);
        chk("pp_head", 32'(RdData), 32'h11);
        for (int i = 1; i < 8; i++) begin
            chk("pp_drain", 32'(RdData), 32'h10 + 32'(i));
            RdReady = 1'b1;
            tick();
            RdReady = 1'b0;
        end
        chk("pp_last", 32'(RdData), 32'hBB);
        RdReady = 1'b1;
        tick();
        RdReady = 1'b0;
        chk("pp_empty", 32'(Count), 32'd0);
        $display("push/pop while full -> BB returned last");

        // Clear counters and sticky flag
        ClrCnt = 1'b1;
        tick();
        ClrCnt = 1'b0;
        chk("clr_ovf", 32'(Overflow), 32'd0);
        chk("clr_ovfcnt", 32'(OverflowCnt), 32'd0);
        chk("clr_parcnt", 32'(ParityErrCnt), 32'd0);

        // Saturation: 5 bad frames with continuous reads -> 3
        RdReady = 1'b1;
        for (int i = 0; i < 5; i++) begin
            RxFrame = bad(8'h40 + 8'(i)); RxFrameValid = 1'b1;
            tick();
            if (i == 1) chk("sat_two", 32'(ParityErrCnt), 32'd2);
        end
        chk("sat_three", 32'(ParityErrCnt), 32'd3);
        RxFrame = bad(8'h45); ClrCnt = 1'b1;
        tick();
        ClrCnt = 1'b0; RxFrameValid = 1'b0;
        chk("sat_clr", 32'(ParityErrCnt), 32'd0);
        tick();
        RdReady = 1'b0;
        chk("sat_empty", 32'(Count), 32'd0);
        $display("saturation -> 3, clear with bad frame -> %0d", ParityErrCnt);

        // Reset mid-stream with 3 entries stored
        RxFrame = good(8'h01); RxFrameValid = 1'b1;
        tick();
        RxFrame = bad(8'h02);
        tick();
        RxFrame = good(8'h03);
        tick();
        RxFrameValid = 1'b0;
        chk("mid_count", 32'(Count), 32'd3);
        chk("mid_parcnt", 32'(ParityErrCnt), 32'd1);
        #2 Rst = 1'b1;
        #1;
        chk("arst_count", 32'(Count), 32'd0);
        chk("arst_valid", 32'(RdValid), 32'd0);
        chk("arst_parcnt", 32'(ParityErrCnt), 32'd0);
        chk("arst_data", 32'(RdData), 32'd0);
        tick();
        Rst = 1'b0;
        RxFrame = good(8'h3C); RxFrameValid = 1'b1;
        tick();
        RxFrameValid = 1'b0;
        chk("post_rst_data", 32'(RdData), 32'h3C);
        chk("post_rst_count", 32'(Count), 32'd1);
        $display("reset mid-stream -> first read %0h", RdData);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
